// File: rtl/feature_point_collector.sv
// Feature-point collector: tracks raster position of the filtered pixel stream,
// queues thresholded in-border pixels as (x, y, mag) records, and reports per-frame stats.
module feature_point_collector #(
  parameter int WIDTH        = 420,
  parameter int HEIGHT       = 320,
  parameter int BORDER       = 2,
  parameter int DEPTH        = 16,
  parameter int MAX_FEATURES = 200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       validin,
  input  logic       blanking_in,
  input  logic [7:0] threshold,
  output logic [8:0] out_x,
  output logic [8:0] out_y,
  output logic [7:0] out_mag,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       frame_done,
  output logic [7:0] frame_count,
  output logic       frame_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [8:0] X_LAST = 9'(WIDTH - 1);
  localparam logic [8:0] Y_LAST = 9'(HEIGHT - 1);
  localparam logic [8:0] X_LO   = 9'(BORDER);
  localparam logic [8:0] X_HI   = 9'(WIDTH - 1 - BORDER);
  localparam logic [8:0] Y_LO   = 9'(BORDER);
  localparam logic [8:0] Y_HI   = 9'(HEIGHT - 1 - BORDER);
  localparam logic [7:0] CAP    = 8'(MAX_FEATURES);

  typedef struct packed {
    logic [8:0] x;
    logic [8:0] y;
    logic [7:0] mag;
  } rec_t;

  rec_t          mem_q [DEPTH];

  logic [8:0]    x_q, x_d;
  logic [8:0]    y_q, y_d;
  logic [7:0]    thr_q, thr_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          frame_done_q, frame_done_d;
  logic [7:0]    frame_count_q, frame_count_d;
  logic          frame_overflow_q, frame_overflow_d;

  logic          empty, full, pop, push, drop, eligible, eof_beat;
  logic          in_border;
  logic [7:0]    cnt_next;
  logic          ovf_next;
  rec_t          push_rec;
  rec_t          head;

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    x_d              = x_q;
    y_d              = y_q;
    thr_d            = thr_q;
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    frame_done_d     = 1'b0;
    frame_count_d    = frame_count_q;
    frame_overflow_d = frame_overflow_q;

    empty     = (wr_ptr_q == rd_ptr_q);
    full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop       = !empty && out_ready;

    in_border = (x_q >= X_LO) && (x_q <= X_HI) && (y_q >= Y_LO) && (y_q <= Y_HI);
    eligible  = validin && !blanking_in && (din >= thr_q) && in_border && (cnt_q < CAP);
    // A pop in the same cycle frees the slot being written, so a full FIFO can still accept.
    push      = eligible && (!full || pop);
    drop      = eligible && !push;
    eof_beat  = validin && (x_q == X_LAST) && (y_q == Y_LAST);
    push_rec  = '{x: x_q, y: y_q, mag: din};

    if (validin) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 9'd1;
      end else begin
        x_d = x_q + 9'd1;
      end
    end

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

    cnt_next = cnt_q + {7'd0, push};
    ovf_next = ovf_q | drop;

    if (eof_beat) begin
      frame_done_d     = 1'b1;
      frame_count_d    = cnt_next;
      frame_overflow_d = ovf_next;
      cnt_d            = '0;
      ovf_d            = 1'b0;
      thr_d            = threshold;
    end else begin
      cnt_d            = cnt_next;
      ovf_d            = ovf_next;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      x_q              <= '0;
      y_q              <= '0;
      thr_q            <= threshold;
      cnt_q            <= '0;
      ovf_q            <= 1'b0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      frame_done_q     <= 1'b0;
      frame_count_q    <= '0;
      frame_overflow_q <= 1'b0;
    end else begin
      x_q              <= x_d;
      y_q              <= y_d;
      thr_q            <= thr_d;
      cnt_q            <= cnt_d;
      ovf_q            <= ovf_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      frame_done_q     <= frame_done_d;
      frame_count_q    <= frame_count_d;
      frame_overflow_q <= frame_overflow_d;
    end
  end

  // NOTE: the storage array is not reset; the pointers alone define which
  // entries are live, and the outputs are masked while the FIFO is empty.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= push_rec;
  end

  assign head           = mem_q[rd_ptr_q[AW-1:0]];
  assign out_valid      = !empty;
  assign out_x          = out_valid ? head.x   : '0;
  assign out_y          = out_valid ? head.y   : '0;
  assign out_mag        = out_valid ? head.mag : '0;
  assign frame_done     = frame_done_q;
  assign frame_count    = frame_count_q;
  assign frame_overflow = frame_overflow_q;

endmodule

// File: tb/tb_feature_point_collector.sv
// Scoreboard bench for feature_point_collector on an 8x4 raster with a 4-entry FIFO.
// Stimulus queues expected records/frame stats; a negedge monitor compares them.
module tb_feature_point_collector;

  localparam int W = 8;
  localparam int H = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] din = '0;
  logic       validin = 1'b0;
  logic       blanking_in = 1'b0;
  logic [7:0] threshold = 8'd100;
  logic [8:0] out_x, out_y;
  logic [7:0] out_mag;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       frame_done;
  logic [7:0] frame_count;
  logic       frame_overflow;

  feature_point_collector #(
    .WIDTH(W), .HEIGHT(H), .BORDER(1), .DEPTH(4), .MAX_FEATURES(6)
  ) dut (
    .clock(clock), .reset(reset), .din(din), .validin(validin),
    .blanking_in(blanking_in), .threshold(threshold),
    .out_x(out_x), .out_y(out_y), .out_mag(out_mag), .out_valid(out_valid),
    .out_ready(out_ready), .frame_done(frame_done),
    .frame_count(frame_count), .frame_overflow(frame_overflow)
  );

  always #5 clock = ~clock;

  typedef struct { int x; int y; int mag; } rec_t;
  typedef struct { int cnt; int ovf; } frm_t;

  rec_t exp_q[$];
  frm_t fq[$];
  rec_t mon_e;
  frm_t mon_f;

  logic [7:0] pix_d [W*H];
  logic       pix_b [W*H];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  task automatic clear_frame();
    for (int i = 0; i < W*H; i++) begin
      pix_d[i] = 8'd0;
      pix_b[i] = 1'b0;
    end
  endtask

  task automatic set_px(input int x, input int y, input int d, input bit b);
    pix_d[y*W + x] = 8'(d);
    pix_b[y*W + x] = b;
  endtask

  task automatic exp_rec(input int x, input int y, input int m);
    rec_t r;
    r.x = x; r.y = y; r.mag = m;
    exp_q.push_back(r);
  endtask

  task automatic exp_frame(input int c, input int o);
    frm_t f;
    f.cnt = c; f.ovf = o;
    fq.push_back(f);
  endtask

  // Each call starts and ends 1 time unit after a rising edge.
  task automatic send_range(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      validin     = 1'b1;
      din         = pix_d[i];
      blanking_in = pix_b[i];
      @(posedge clock); #1;
      validin     = 1'b0;
      din         = 8'd0;
      blanking_in = 1'b0;
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && (exp_q.size() != 0 || fq.size() != 0); i++) begin
      @(posedge clock); #1;
    end
    check("drain_records", exp_q.size(), 0);
    check("drain_frames", fq.size(), 0);
  endtask

  // Monitor: compares the FIFO head against the scoreboard, popping on a handshake.
  always @(negedge clock) begin
    if (!reset) begin
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_record", out_valid, 0);
        end else begin
          mon_e = out_ready ? exp_q.pop_front() : exp_q[0];
          check("rec_x", out_x, mon_e.x);
          check("rec_y", out_y, mon_e.y);
          check("rec_mag", out_mag, mon_e.mag);
        end
      end
      if (frame_done !== 1'b0) begin
        if (fq.size() == 0) begin
          check("unexpected_frame_done", frame_done, 0);
        end else begin
          mon_f = fq.pop_front();
          check("frame_count", frame_count, mon_f.cnt);
          check("frame_overflow", frame_overflow, mon_f.ovf);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_x", out_x, 0);
    check("reset_out_y", out_y, 0);
    check("reset_out_mag", out_mag, 0);
    check("reset_frame_done", frame_done, 0);
    check("reset_frame_count", frame_count, 0);
    check("reset_frame_overflow", frame_overflow, 0);
    reset = 1'b0;

    // Single feature at (3,2), one-cycle latency, frame_done pulse
    clear_frame();
    set_px(3, 2, 150, 0);
    exp_rec(3, 2, 150);
    exp_frame(1, 0);
    send_range(0, 18);
    check("latency_before", out_valid, 0);
    send_range(19, 19);
    check("latency_after", out_valid, 1);
    send_range(20, 31);
    check("frame_done_high", frame_done, 1);
    @(posedge clock); #1;
    check("frame_done_one_cycle", frame_done, 0);
    wait_idle();

    // Border suppression and inclusive threshold
    clear_frame();
    set_px(0, 1, 255, 0);
    set_px(7, 2, 255, 0);
    set_px(3, 0, 255, 0);
    set_px(3, 3, 255, 0);
    set_px(2, 1, 99, 0);
    set_px(4, 1, 100, 0);
    exp_rec(4, 1, 100);
    exp_frame(1, 0);
    send_range(0, 31);
    wait_idle();

    // Blanking advances position; idle gaps do not
    clear_frame();
    set_px(2, 2, 255, 1);
    set_px(3, 2, 200, 0);
    exp_rec(3, 2, 200);
    exp_frame(1, 0);
    send_range(0, 18);
    repeat (3) @(posedge clock);
    #1;
    send_range(19, 31);
    wait_idle();

    // Overflow with a stalled consumer
    out_ready = 1'b0;
    clear_frame();
    for (int x = 1; x <= 5; x++) set_px(x, 1, 200, 0);
    for (int x = 1; x <= 4; x++) exp_rec(x, 1, 200);
    exp_frame(4, 1);
    send_range(0, 31);
    repeat (3) @(posedge clock);
    #1;
    check("stalled_valid", out_valid, 1);
    out_ready = 1'b1;
    wait_idle();

    // Per-frame cap, then the count restarts next frame
    clear_frame();
    for (int y = 1; y <= 2; y++)
      for (int x = 1; x <= 6; x++) set_px(x, y, 200, 0);
    for (int x = 1; x <= 6; x++) exp_rec(x, 1, 200);
    exp_frame(6, 0);
    send_range(0, 31);
    wait_idle();
    clear_frame();
    set_px(2, 1, 200, 0);
    exp_rec(2, 1, 200);
    exp_frame(1, 0);
    send_range(0, 31);
    wait_idle();

    // Threshold change takes effect only at the next frame
    clear_frame();
    set_px(1, 1, 200, 0);
    set_px(4, 2, 150, 0);
    exp_rec(1, 1, 200);
    exp_rec(4, 2, 150);
    exp_frame(2, 0);
    send_range(0, 12);
    threshold = 8'd200;
    send_range(13, 31);
    wait_idle();
    clear_frame();
    set_px(4, 2, 150, 0);
    set_px(5, 2, 200, 0);
    exp_rec(5, 2, 200);
    exp_frame(1, 0);
    send_range(0, 31);
    wait_idle();

    // Mid-frame reset discards queued records and restarts position
    out_ready = 1'b0;
    clear_frame();
    set_px(1, 1, 200, 0);
    set_px(2, 1, 210, 0);
    exp_rec(1, 1, 200);
    exp_rec(2, 1, 210);
    send_range(0, 11);
    check("pre_reset_valid", out_valid, 1);
    reset = 1'b1;
    @(posedge clock); #1;
    check("mid_reset_out_valid", out_valid, 0);
    check("mid_reset_frame_count", frame_count, 0);
    exp_q.delete();
    reset = 1'b0;
    out_ready = 1'b1;
    clear_frame();
    set_px(1, 1, 200, 0);
    exp_rec(1, 1, 200);
    exp_frame(1, 0);
    send_range(0, 31);
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/feature_point_collector.md
Name: feature_point_collector

Overview:
- Sits directly downstream of the 5x5 window filter and consumes its raster pixel stream (dout/validout/blanking_out).
- Tracks raster position per valid beat and flags pixels at or above a programmable threshold, inside a border margin, as feature points.
- Queues (x, y, magnitude) records in a small FIFO with a ready/valid readout port.
- Publishes per-frame feature count and overflow status at each end of frame.

Parameters:
WIDTH, 420, pixels per line; must equal the upstream window's width
HEIGHT, 320, lines per frame
BORDER, 2, margin in pixels/lines on every edge where detection is suppressed (invalid 5x5 support)
DEPTH, 16, FIFO entries; power of two, at least 2
MAX_FEATURES, 200, per-frame cap on accepted records; at most 255

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
din  in  8  filtered pixel from the window stage
validin  in  1  din/blanking_in are a valid beat
blanking_in  in  1  beat is a blanking pixel; never eligible, but still advances position
threshold  in  8  detection threshold; sampled per frame
out_x  out  9  feature column
out_y  out  9  feature row
out_mag  out  8  feature pixel value
out_valid  out  1  FIFO head is valid
out_ready  in  1  consumer accepts head
frame_done  out  1  one-cycle pulse after the last beat of a frame
frame_count  out  8  accepted records in the last completed frame
frame_overflow  out  1  at least one record dropped (FIFO full) in the last completed frame

Behaviour:
- Reset: x_cnt=0, y_cnt=0, FIFO empty, out_valid=0, out_x/out_y/out_mag=0, frame_done=0, frame_count=0, frame_overflow=0, internal count and overflow cleared, thr_q<=threshold.
- Reset mid-frame discards the FIFO contents and the partial frame. The next validin beat is (0,0).
- Position:
  - Each validin beat occupies the current (x_cnt, y_cnt).
  - x_cnt wraps WIDTH-1 -> 0 and then increments y_cnt.
  - y_cnt wraps HEIGHT-1 -> 0.
  - No movement without validin.
- Eligible beat requires all of:
  - validin=1 and blanking_in=0
  - din >= thr_q (unsigned)
  - BORDER <= x_cnt <= WIDTH-1-BORDER
  - BORDER <= y_cnt <= HEIGHT-1-BORDER
  - internal count < MAX_FEATURES
- Eligible beats at or above the cap are silently ignored and do not set overflow.
- Push:
  - An eligible beat pushes {x_cnt, y_cnt, din} if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the record is dropped and internal overflow is set.
  - An accepted push increments the internal count.
- Latency: a record pushed into an empty FIFO shows out_valid=1 on the cycle after its beat.
- FIFO ordering and handshake:
  - Output is FIFO-ordered and first-word-fall-through.
  - Pop occurs when out_valid & out_ready.
  - out_x/out_y/out_mag are stable while out_valid=1 and out_ready=0.
  - Contents are don't-care when out_valid=0.
  - Empty with push and pop in the same cycle: no pop; push lands and out_valid rises next cycle.
- End of frame (beat at x=WIDTH-1, y=HEIGHT-1), effects on the next cycle:
  - frame_done=1 for exactly one cycle.
  - frame_count <= internal count, including any push from the last beat.
  - frame_overflow <= internal overflow, including any drop from the last beat.
  - Internal count and overflow clear.
  - thr_q <= threshold.
- FIFO contents are not flushed at frame boundaries; records carry over.
- Widths:
  - Counters are 9 bits; WIDTH and HEIGHT must be at most 512.
  - FIFO pointers are log2(DEPTH)+1 bits.
  - Internal count is 8 bits and saturates via the cap.
- Changes on threshold mid-frame have no effect until the next frame boundary.

Test Plan:
- Bench params: WIDTH=8, HEIGHT=4, BORDER=1, DEPTH=4, MAX_FEATURES=6.
- Reset, threshold=100. Stream one frame of 32 beats with din=0 except din=150 at (3,2) -> exactly one record: out_x=3, out_y=2, out_mag=150, out_valid one cycle after that beat. frame_done pulses after beat 32 with frame_count=1, frame_overflow=0.
- Border: din=255 at (0,1), (7,2), (3,0) and (3,3); din=99 at (2,1); din=100 at (4,1) -> only (4,1) is recorded (threshold inclusive). frame_count=1.
- blanking_in=1 with din=255 at (2,2) -> no record, but the position still advances: a din=200 beat on the following valid beat records x=3, y=2. Gaps in validin do not move position.
- Overflow: out_ready=0, and 5 eligible pixels in a row on line 1 -> 4 records held, fifth dropped. frame_overflow=1 and frame_count=4 at frame_done. Draining returns x=1,2,3,4 in order.
- Cap: out_ready=1 and 12 eligible pixels across rows 1-2 -> only the first 6 are popped. frame_count=6, frame_overflow=0. Next frame starts with count 0.
- Change threshold to 200 mid-frame: a din=150 pixel in the same frame is still recorded, and in the next frame is not. Assert reset mid-frame with 2 records queued -> out_valid=0 the next cycle and position restarts at (0,0).
